// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct
// codes, FSM states, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ORI = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALU B operand select
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // FSM states; 12-15 are unused and fall back to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: ALU operation plus a supported flag.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alucontrol_o,
  output logic       funct_valid_o
);

  // Map funct to ALU code; unsupported funct reports invalid and ADD
  always_comb begin
    alucontrol_o  = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  alucontrol_o = ALU_ADD;
      FN_SUB:  alucontrol_o = ALU_SUB;
      FN_AND:  alucontrol_o = ALU_AND;
      FN_OR:   alucontrol_o = ALU_OR;
      FN_SLT:  alucontrol_o = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath. One micro-step per
// cycle; all datapath controls decode from the current state (plus op,
// funct and zero where an instruction needs them).
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  state_t     cur_s;
  logic [3:0] rt_alu;
  logic       funct_ok;
  logic       op_ok;
  logic       pcwrite, branch;
  logic       irwrite_s, memwrite_s, regwrite_s, illegal_s;

  alu_decoder u_alu_dec (
    .funct_i       (funct),
    .alucontrol_o  (rt_alu),
    .funct_valid_o (funct_ok)
  );

  // Instruction is supported when the opcode is known and, for R-type,
  // the funct is one the ALU decoder accepts
  always_comb begin
    case (op)
      OP_RTYPE:                              op_ok = funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: op_ok = 1'b1;
      default:                               op_ok = 1'b0;
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op_ok) begin
          case (op)
            OP_LW, OP_SW:    state_d = S_MEMADR;
            OP_RTYPE:        state_d = S_RTYPEEX;
            OP_BEQ:          state_d = S_BEQEX;
            OP_ADDI, OP_ORI: state_d = S_IMMEX;
            OP_J:            state_d = S_JEX;
            default:         state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_IMMEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // While reset is held the outputs present FETCH, so nothing downstream
  // sees the aborted instruction's controls
  assign cur_s = reset ? S_FETCH : state_q;
  assign state = cur_s;

  // Output decode
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RD2;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = PC_ALU;
    alucontrol = ALU_AND;
    case (cur_s)
      S_FETCH: begin
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        irwrite_s  = 1'b1;
        pcwrite    = 1'b1;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMMSH;
        alucontrol = ALU_ADD;
        illegal_s  = ~op_ok;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rt_alu;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        branch     = 1'b1;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        // ORI code with the immediate select tells the extender to zero-extend
        alucontrol = (op == OP_ORI) ? ALU_ORI : ALU_ADD;
      end
      S_IMMWB: regwrite_s = 1'b1;
      S_JEX: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural strobes are suppressed for the whole reset cycle
  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign irwrite  = ~reset & irwrite_s;
  assign memwrite = ~reset & memwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign illegal  = ~reset & illegal_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each instruction pushes its
// expected per-cycle control vectors to a scoreboard, popped one per cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol, state;

  int tests = 0;
  int fails = 0;

  typedef logic [20:0] vec_t;
  vec_t exp_q[$];
  vec_t got;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .regdst(regdst),
    .memtoreg(memtoreg), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  assign got = {state, pcen, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
                regdst, memtoreg, pcsrc, alucontrol, illegal};

  // Reference control vector for one state, written from the state table
  function automatic vec_t exp_vec(int s, logic [5:0] o, logic [5:0] f, logic z);
    logic [3:0] st = 4'(s);
    logic pe = 0, irw = 0, mw = 0, rw = 0, io = 0, sa = 0, rd = 0, m2r = 0, il = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [3:0] ac = 4'b0000;
    case (s)
      0: begin sb = 2'b01; ac = 4'b0010; irw = 1; pe = 1; end
      1: begin
        sb = 2'b11; ac = 4'b0010;
        if (o == 6'b000000)
          il = !(f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
        else
          il = !(o inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010});
      end
      2: begin sa = 1; sb = 2'b10; ac = 4'b0010; end
      3: io = 1;
      4: begin m2r = 1; rw = 1; end
      5: begin io = 1; mw = 1; end
      6: begin
        sa = 1;
        case (f)
          6'b100000: ac = 4'b0010;
          6'b100010: ac = 4'b0110;
          6'b100100: ac = 4'b0000;
          6'b100101: ac = 4'b0001;
          default:   ac = 4'b0111;
        endcase
      end
      7: begin rd = 1; rw = 1; end
      8: begin sa = 1; ac = 4'b0110; ps = 2'b01; pe = z; end
      9: begin sa = 1; sb = 2'b10; ac = (o == 6'b001101) ? 4'b0101 : 4'b0010; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {st, pe, irw, mw, rw, io, sa, sb, rd, m2r, ps, ac, il};
  endfunction

  localparam vec_t RST_VEC = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01,
                              1'b0, 1'b0, 2'b00, 4'b0010, 1'b0};

  task automatic check(string tag, vec_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s state=%0d observed=%h expected=%h", tag, state, got, exp);
    end
  endtask

  // Push the instruction's expected cycles; optionally pop only the first n
  task automatic run_instr(string tag, logic [5:0] o, logic [5:0] f, logic z, int n = 99);
    int sq[$];
    vec_t e;
    op = o; funct = f; zero = z;
    case (o)
      6'b100011: sq = '{0, 1, 2, 3, 4};
      6'b101011: sq = '{0, 1, 2, 5};
      6'b000000: sq = (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                      ? '{0, 1, 6, 7} : '{0, 1};
      6'b000100: sq = '{0, 1, 8};
      6'b001000, 6'b001101: sq = '{0, 1, 9, 10};
      6'b000010: sq = '{0, 1, 11};
      default:   sq = '{0, 1};
    endcase
    foreach (sq[i]) exp_q.push_back(exp_vec(sq[i], o, f, z));
    while (exp_q.size() > 0 && n > 0) begin
      #1;
      e = exp_q.pop_front();
      check(tag, e);
      n--;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1; op = 6'b000000; funct = 6'b100000; zero = 0;
    #1 check("reset_pre_edge", RST_VEC);
    @(posedge clk); @(negedge clk);
    check("reset_held", RST_VEC);
    reset = 0;

    run_instr("lw",        6'b100011, 6'b000000, 1'b0);
    run_instr("sw",        6'b101011, 6'b000000, 1'b0);
    run_instr("sub",       6'b000000, 6'b100010, 1'b0);
    run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1);
    run_instr("beq_not",   6'b000100, 6'b000000, 1'b0);
    run_instr("ori",       6'b001101, 6'b000000, 1'b0);
    run_instr("addi",      6'b001000, 6'b000000, 1'b0);
    run_instr("j",         6'b000010, 6'b000000, 1'b0);
    run_instr("illegal_op",6'b111111, 6'b000000, 1'b0);
    run_instr("slt",       6'b000000, 6'b101010, 1'b0);
    run_instr("bad_funct", 6'b000000, 6'b000111, 1'b0);

    // Abort a lw in MEMRD: strobes stay low and fetch restarts
    run_instr("lw_abort",  6'b100011, 6'b000000, 1'b0, 3);
    exp_q.delete();
    reset = 1;
    #1 check("reset_in_memrd", RST_VEC);
    @(posedge clk); @(negedge clk);
    check("reset_after_edge", RST_VEC);
    reset = 0;
    run_instr("and_after_rst", 6'b000000, 6'b100100, 1'b0);
    run_instr("or",            6'b000000, 6'b100101, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared multicycle MIPS datapath: regfile, ALU, single memory, instruction register, and the PC register.
- Takes opcode/funct from the instruction register and the ALU zero flag.
- Drives every datapath enable and mux select, one micro-step per cycle.
- Supported instructions: lw, sw, R-type (add, sub, and, or, slt), beq, addi, ori, j.

Parameters:
- None. All encodings are fixed in the shared package.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable = pcwrite | (branch & zero)
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write strobe
- regwrite  out  1  regfile we3
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- alusrca  out  1  ALU A select: 0=PC, 1=rd1
- alusrcb  out  2  ALU B select: 00=rd2, 01=const 4, 10=ext imm, 11=ext imm<<2
- regdst  out  1  write address select: 0=rt, 1=rd
- memtoreg  out  1  write data select: 0=ALUOut, 1=mem data
- pcsrc  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target
- alucontrol  out  4  ALU operation code
- illegal  out  1  one-cycle pulse on unsupported op/funct
- state  out  4  current state (debug/verification)

Behaviour:
- Reset is synchronous: state <= FETCH at the edge where reset=1.
- While reset=1, pcen, irwrite, memwrite, regwrite and illegal are forced 0; all other outputs show FETCH values.
- Reset mid-instruction aborts it; no write is issued in that cycle.
- All outputs decode combinationally from state (plus op/funct/zero where noted).
- Unlisted signals are 0 in every state.
- State encoding and outputs:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, alucontrol=ADD, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE(1): alusrca=0, alusrcb=11, alucontrol=ADD (branch target precompute).
  - MEMADR(2): alusrca=1, alusrcb=10, ADD.
  - MEMRD(3): iord=1.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1.
  - MEMWR(5): iord=1, memwrite=1.
  - RTYPEEX(6): alusrca=1, alusrcb=00, alucontrol from funct decoder.
  - RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1.
  - BEQEX(8): alusrca=1, alusrcb=00, SUB, pcsrc=01, branch=1.
  - IMMEX(9): alusrca=1, alusrcb=10, alucontrol=ADD for addi, ORI(0101) for ori. Code 0101 with alusrcb=10 makes the extender zero-extend.
  - IMMWB(10): regdst=0, memtoreg=0, regwrite=1.
  - JEX(11): pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE->MEMADR for lw/sw; RTYPEEX for R-type with supported funct; BEQEX for beq; IMMEX for addi/ori; JEX for j.
  - DECODE->FETCH for any other op, or R-type with unsupported funct; illegal=1 during that DECODE cycle. No architectural write occurs; PC has already advanced by 4.
  - MEMADR->MEMRD (lw) or MEMWR (sw).
  - MEMRD->MEMWB.
  - RTYPEEX->RTYPEWB.
  - IMMEX->IMMWB.
  - MEMWB, MEMWR, RTYPEWB, IMMWB, BEQEX, JEX -> FETCH.
- ALU codes: AND=0000, OR=0001, ADD=0010, ORI=0101, SUB=0110, SLT=0111.
- Funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, ori=001101, j=000010.
- Latency in cycles, FETCH through return to FETCH: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3, illegal 2.
- beq: pcen in BEQEX = zero. zero=0 gives no PC update.
- Encodings 12-15 are unreachable; if entered, next state is FETCH and all strobes are 0.

Decomposition:
- Package mips_ctrl_pkg holds opcode constants, funct constants, state encodings, alucontrol codes, and alusrcb/pcsrc select codes.
- One sub-module: alu_decoder. It is combinational and maps funct to {alucontrol, funct_valid}; it is instanced once in the controller.

Test Plan:
- lw (op=100011) after reset release: states 0,1,2,3,4. irwrite=pcen=1 only in cycle 0. iord=1 in MEMRD. regwrite=1, memtoreg=1 only in MEMWB.
- sw then R-type sub (funct=100010): sw gives memwrite=1 exactly one cycle in state 5. sub shows alucontrol=0110 in state 6, then regwrite=1 with regdst=1 in state 7.
- beq, zero=1 then zero=0: states 0,1,8. pcen=1, pcsrc=01 in state 8 only when zero=1. The second pass shows pcen=0 in state 8.
- ori (op=001101) then addi: IMMEX shows alucontrol=0101, alusrcb=10 for ori, and 0010 for addi. IMMWB shows regwrite=1, regdst=0.
- j, then illegal op=111111: j gives states 0,1,11 with pcsrc=10, pcen=1. The illegal op gives illegal=1 in DECODE, next state FETCH, no regwrite/memwrite.
- Reset asserted in MEMRD of a lw: next state FETCH. No regwrite in any cycle; strobes stay 0 while reset=1. Fetch resumes normally after release.
